// File: rtl/arith_pkg.sv
// Shared helpers for the arithmetic datapath blocks: slice sizing and legality checks.
package arith_pkg;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Width of one carry-chain slice; a zero stage count degrades to a single slice.
  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // A pipeline split is legal when every slice has the same non-zero width.
  function automatic bit stages_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its MSB.
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit adder: carry chain split into STAGES registered slices, valid/ready flow.
module adder_pipe_nbit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned SLICE_W = slice_w(WIDTH, STAGES);

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of STAGES");
  end

  // Pipeline state: per-stage valid, skewed sum/operand-A bits, pending operand-B bits, carry.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [STAGES-1:0] rc;
  logic              ovf_q;

  // Stage inputs and slice results.
  logic [WIDTH-1:0]   sa  [STAGES];
  logic [WIDTH-1:0]   sb  [STAGES];
  logic [WIDTH-1:0]   na  [STAGES];
  logic [SLICE_W-1:0] ss  [STAGES];
  logic               sc  [STAGES];
  logic               sco [STAGES];
  logic               scm [STAGES];
  logic [STAGES-1:0]  vin;
  logic               down_ld;

  // Load enables ripple backwards from out_ready so a stalled pipe still fills its bubbles.
  always_comb begin
    ld      = '0;
    down_ld = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ld[k]   = !v[k] || down_ld;
      down_ld = ld[k];
    end
  end

  assign in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE_W{1'b1}}) << (k * SLICE_W);

    // Stage 0 sees the ports; later stages see the previous stage's registers.
    if (k == 0) begin : g_first
      assign sa[k]  = a;
      assign sb[k]  = b;
      assign sc[k]  = c_in;
      assign vin[k] = in_valid;
    end else begin : g_next
      assign sa[k]  = ra[k-1];
      assign sb[k]  = rb[k-1];
      assign sc[k]  = rc[k-1];
      assign vin[k] = v[k-1];
    end

    adder_slice #(.W(SLICE_W)) u_slice (
      .a        (sa[k][k*SLICE_W +: SLICE_W]),
      .b        (sb[k][k*SLICE_W +: SLICE_W]),
      .cin      (sc[k]),
      .s        (ss[k]),
      .cout     (sco[k]),
      .c_msb_in (scm[k])
    );

    // Replace this stage's operand-A slice with its freshly computed sum bits.
    assign na[k] = (sa[k] & ~MASK) | (WIDTH'(ss[k]) << (k * SLICE_W));
  end

  // Advance the valid chain; data registers only move when a real operation arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      rc    <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (ld[k]) begin
          v[k] <= vin[k];
          if (vin[k]) begin
            ra[k] <= na[k];
            rb[k] <= sb[k];
            rc[k] <= sco[k];
          end
        end
      end
      if (ld[STAGES-1] && vin[STAGES-1]) begin
        ovf_q <= sco[STAGES-1] ^ scm[STAGES-1];
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign sum       = ra[STAGES-1];
  assign c_out     = rc[STAGES-1];
  assign ovf       = ovf_q;

endmodule
